// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
//   state_t        : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W / BE_W  : word width and matching byte-enable width
//   DEFAULT_DEPTH  : default number of stored words
package data_mem_responder_pkg;

  localparam int DATA_W        = 32;
  localparam int BE_W          = DATA_W / 8;
  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
//   clk   : clock
//   en    : access strobe; one read or write per strobed edge
//   we    : 1 = write enabled bytes, 0 = read the whole word
//   be    : byte enables, bit k covers bits 8k+7..8k
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, held until the next read strobe
// Storage is not reset; contents are undefined until written.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store request at a time over a
// valid/ready handshake, waits WAIT_CYCLES extra cycles, then presents a
// response held until the initiator takes it.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid_i/ready_o : request handshake (ready only while idle)
//   req_we_i            : 1 = store, 0 = load
//   req_addr_i          : byte address
//   req_wdata_i         : store data
//   req_be_i            : store byte enables
//   rsp_valid_o/ready_i : response handshake
//   rsp_rdata_o         : load data (0 for stores and errors)
//   rsp_err_o           : misaligned or out-of-range request
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_d;
  logic [3:0]        wait_cnt, wait_cnt_d;
  logic              accept;
  logic              req_err;
  logic              enter_resp;

  logic [AW-1:0]     idx_p0;
  logic              we_p0;
  logic              err_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [BE_W-1:0]   be_p0;

  logic              in_idle;
  logic              mem_en;
  logic              mem_we;
  logic              mem_err;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  // Ready is withheld during reset so requests presented then are ignored.
  assign req_ready_o = (state == IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;

  // Any set bit above the word index range means the word lies past DEPTH.
  assign req_err = (req_addr_i[1:0] != 2'b00) || (|req_addr_i[31:AW+2]);

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // ---- stage p0: request captured on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= req_addr_i[AW+1:2];
      we_p0    <= req_we_i;
      err_p0   <= req_err;
      wdata_p0 <= req_wdata_i;
      be_p0    <= req_be_i;
    end
  end

  // With WAIT_CYCLES=0 the RAM access happens on the accept edge itself, so
  // the live request is used; otherwise the captured copy is.
  assign in_idle   = (state == IDLE);
  assign mem_idx   = in_idle ? req_addr_i[AW+1:2] : idx_p0;
  assign mem_we    = in_idle ? req_we_i           : we_p0;
  assign mem_err   = in_idle ? req_err            : err_p0;
  assign mem_wdata = in_idle ? req_wdata_i        : wdata_p0;
  assign mem_be    = in_idle ? req_be_i           : be_p0;

  // Erroneous requests never touch storage; reset cancels a pending access.
  assign mem_en = enter_resp && !rst && !mem_err;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // ---- stage p1: response ----
  // The RAM is not strobed while in RESP, so its read register stays stable
  // for as long as the response is held.
  assign rsp_valid_o = (state == RESP);
  assign rsp_err_o   = rsp_valid_o && err_p0;
  assign rsp_rdata_o = (rsp_valid_o && !err_p0 && !we_p0) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH  = 64;
  localparam int WC     = 1;
  localparam int DEPTH0 = 16;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_be_i(req_be0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model: sparse word store ----------------
  logic [31:0] m_data  [int];
  logic [3:0]  m_known [int];

  function automatic logic m_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    int idx;
    logic [31:0] w;
    logic [3:0]  k;
    if (m_err(a)) return;
    idx = int'(a / 4);
    w = m_data.exists(idx)  ? m_data[idx]  : 32'h0;
    k = m_known.exists(idx) ? m_known[idx] : 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        w[8*b +: 8] = d[8*b +: 8];
        k[b] = 1'b1;
      end
    end
    m_data[idx]  = w;
    m_known[idx] = k;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake, expected one within the cycle budget", nm);
  endtask

  // One complete transaction; hold = cycles the response is left waiting,
  // during which a competing request is presented.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    rdata = 'x;
    err   = 1'bx;
    lat   = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      timeout("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) begin
      timeout("rsp_timeout");
      return;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rdata);
      chk("hold_err",   rsp_err,   err);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_ready",     req_ready, 1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    int          n;

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;

    // Reset with requests pending; they must be ignored.
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
    req_valid0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
    @(negedge clk);
    chk("rst_ready",  req_ready, 1);
    chk("rst_valid",  rsp_valid, 0);
    chk("rst_rdata",  rsp_rdata, 0);
    chk("rst_err",    rsp_err,   0);
    chk("rst_ready0", req_ready0, 1);
    chk("rst_valid0", rsp_valid0, 0);

    // ---------------- directed vectors ----------------
    tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 1, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h3, 0, 32'hAA22_CC44, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b0, DEPTH * 4,     32'h0,         4'hF, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b1, DEPTH * 4,     32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 5, 32'hAA22_CC44, 1'b0});
    tbl.push_back('{1'b1, (DEPTH-1) * 4, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, (DEPTH-1) * 4, 32'h0,         4'hF, 2, 32'h0BAD_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 0, 32'h0,         1'b0});

    foreach (tbl[i]) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, r, e, lat);
      chk($sformatf("vec%0d_latency", i), lat, 1 + WC);
      chk($sformatf("vec%0d_err", i),     e,   tbl[i].exp_err);
      chk($sformatf("vec%0d_rdata", i),   r,   tbl[i].exp_rdata);
      if (tbl[i].we) model_store(tbl[i].addr, tbl[i].wdata, tbl[i].be);
    end

    // ---------------- reset while a store waits ----------------
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678; req_be = 4'hF;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_wait", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_err",   rsp_err,   0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", req_ready, 1);
    chk("abort_no_accept",  rsp_valid, 0);
    txn(1'b0, 32'h40, 32'h0, 4'hF, 0, r, e, lat);
    chk("abort_load_rdata", r, 32'h0);
    chk("abort_load_err",   e, 0);

    // ---------------- randomized traffic vs. model ----------------
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic        xerr;
      int          hold, idx;
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      hold  = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0:       addr = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        1:       addr = $urandom_range(DEPTH, 4 * DEPTH) << 2;
        2:       addr = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        3:       addr = (DEPTH - 1) << 2;
        default: addr = $urandom_range(0, 15) << 2;
      endcase
      xerr = m_err(addr);
      txn(we, addr, wdata, be, hold, r, e, lat);
      chk("rand_latency", lat, 1 + WC);
      chk("rand_err", e, xerr);
      if (we || xerr) begin
        chk("rand_rdata_zero", r, 32'h0);
      end else begin
        idx = int'(addr / 4);
        if (m_known.exists(idx) && m_known[idx] == 4'hF) chk("rand_load", r, m_data[idx]);
      end
      if (we) model_store(addr, wdata, be);
    end

    // ---------------- zero-wait continuous traffic ----------------
    @(negedge clk);
    req_valid0 = 1'b1; rsp_ready0 = 1'b1;
    req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFE_F00D; req_be0 = 4'hF;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("zw%0d_ready", k), req_ready0, (k % 2) == 0);
      chk($sformatf("zw%0d_valid", k), rsp_valid0, (k % 2) == 1);
      if (k == 1) chk("zw_store_rdata", rsp_rdata0, 32'h0);
      if (k >= 3 && (k % 2) == 1) chk($sformatf("zw%0d_load", k), rsp_rdata0, 32'hCAFE_F00D);
      @(posedge clk);
      #1 if (k == 0) req_we0 = 1'b0;
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("zw_end_valid", rsp_valid0, 0);
    chk("zw_end_err",   rsp_err0,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
